// File: rtl/jstk_pkg.sv
// Shared definitions for the PmodJSTK SPI poller: FSM encoding, command byte and frame geometry.
package jstk_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SETUP,
      ST_SHIFT,
      ST_GAP,
      ST_DONE
   } state_e;

   localparam logic [7:0]  CMD_LED     = 8'h80;
   localparam int unsigned FRAME_BYTES = 5;
   localparam int unsigned FRAME_BITS  = 40;

   function automatic logic [7:0] cmd_byte(input logic [1:0] leds);
      return CMD_LED | {6'b0, leds};
   endfunction

endpackage

// File: rtl/spi_byte_shifter.sv
// One 8-bit SPI mode-0 exchange, MSB first; start accepted when idle, done pulses with sclk's last fall.
module spi_byte_shifter #(
   parameter int unsigned HALF_PERIOD = 50
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start_i,
   input  logic [7:0] tx_i,
   input  logic       miso_i,
   output logic       sclk_o,
   output logic       mosi_o,
   output logic       done_o,
   output logic [7:0] rx_o
);

   localparam int unsigned HW = (HALF_PERIOD > 1) ? $clog2(HALF_PERIOD) : 1;

   logic          busy_q;
   logic [HW-1:0] cnt_q;
   logic [2:0]    bit_q;
   logic [7:0]    sh_q;
   logic [7:0]    rx_q;
   logic          sclk_q;
   logic          mosi_q;
   logic          done_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         busy_q <= 1'b0;
         cnt_q  <= '0;
         bit_q  <= '0;
         sh_q   <= '0;
         rx_q   <= '0;
         sclk_q <= 1'b0;
         mosi_q <= 1'b0;
         done_q <= 1'b0;
      end else begin
         done_q <= 1'b0;
         if (!busy_q) begin
            if (start_i) begin
               busy_q <= 1'b1;
               sh_q   <= tx_i;
               mosi_q <= tx_i[7];
               cnt_q  <= '0;
               bit_q  <= '0;
               sclk_q <= 1'b0;
            end
         end else if (cnt_q != HW'(HALF_PERIOD - 1)) begin
            cnt_q <= cnt_q + HW'(1);
         end else begin
            cnt_q <= '0;
            if (!sclk_q) begin
               // rising edge: slave output has been stable for the whole low phase
               sclk_q <= 1'b1;
               rx_q   <= {rx_q[6:0], miso_i};
            end else begin
               sclk_q <= 1'b0;
               if (bit_q == 3'd7) begin
                  busy_q <= 1'b0;
                  done_q <= 1'b1;
               end else begin
                  bit_q  <= bit_q + 3'd1;
                  mosi_q <= sh_q[6];
                  sh_q   <= {sh_q[6:0], 1'b0};
               end
            end
         end
      end
   end

   assign sclk_o = sclk_q;
   assign mosi_o = mosi_q;
   assign done_o = done_q;
   assign rx_o   = rx_q;

endmodule

// File: rtl/jstk_spi_master.sv
// Periodic PmodJSTK poller: frames of five SPI bytes, LED command out, 40-bit joystick frame in.
module jstk_spi_master
   import jstk_pkg::*;
#(
   parameter int unsigned HALF_PERIOD = 50,
   parameter int unsigned SS_SETUP    = 1500,
   parameter int unsigned BYTE_GAP    = 1000,
   parameter int unsigned POLL_PERIOD = 1000000
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  en,
   input  logic [1:0]            leds,
   input  logic                  miso,
   output logic                  ss_n,
   output logic                  sclk,
   output logic                  mosi,
   output logic [FRAME_BITS-1:0] data,
   output logic                  valid
);

   localparam int unsigned TW   = $clog2(POLL_PERIOD + 1);
   localparam int unsigned CMAX = (SS_SETUP > BYTE_GAP) ? SS_SETUP : BYTE_GAP;
   localparam int unsigned CW   = $clog2(CMAX + 1);
   localparam int unsigned BW   = 3;

   state_e                state_q;
   logic [TW-1:0]         tmr_q;
   logic [CW-1:0]         cnt_q;
   logic [BW-1:0]         byte_q;
   logic [1:0]            leds_q;
   logic [FRAME_BITS-1:0] frame_q;
   logic [FRAME_BITS-1:0] data_q;
   logic                  start_q;
   logic                  ss_n_q;
   logic                  valid_q;

   logic                  sh_done;
   logic [7:0]            sh_rx;
   logic [7:0]            sh_tx;

   assign sh_tx = (byte_q == '0) ? cmd_byte(leds_q) : 8'h00;

   spi_byte_shifter #(
      .HALF_PERIOD(HALF_PERIOD)
   ) u_shifter (
      .clk    (clk),
      .rst    (rst),
      .start_i(start_q),
      .tx_i   (sh_tx),
      .miso_i (miso),
      .sclk_o (sclk),
      .mosi_o (mosi),
      .done_o (sh_done),
      .rx_o   (sh_rx)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         tmr_q   <= '0;
         cnt_q   <= '0;
         byte_q  <= '0;
         leds_q  <= '0;
         frame_q <= '0;
         data_q  <= '0;
         start_q <= 1'b0;
         ss_n_q  <= 1'b1;
         valid_q <= 1'b0;
      end else begin
         start_q <= 1'b0;
         valid_q <= 1'b0;
         // free-running poll timer, saturates at zero; reloaded only when a frame starts
         if (tmr_q != '0) tmr_q <= tmr_q - TW'(1);
         case (state_q)
            ST_IDLE: begin
               if (en && tmr_q == '0) begin
                  state_q <= ST_SETUP;
                  ss_n_q  <= 1'b0;
                  leds_q  <= leds;
                  tmr_q   <= TW'(POLL_PERIOD - 1);
                  cnt_q   <= '0;
                  byte_q  <= '0;
               end
            end
            ST_SETUP: begin
               if (cnt_q == CW'(SS_SETUP - 1)) begin
                  cnt_q   <= '0;
                  start_q <= 1'b1;
                  state_q <= ST_SHIFT;
               end else begin
                  cnt_q <= cnt_q + CW'(1);
               end
            end
            ST_SHIFT: begin
               if (sh_done) begin
                  frame_q <= {frame_q[FRAME_BITS-9:0], sh_rx};
                  if (byte_q == BW'(FRAME_BYTES - 1)) begin
                     state_q <= ST_DONE;
                  end else begin
                     byte_q  <= byte_q + BW'(1);
                     state_q <= ST_GAP;
                  end
               end
            end
            ST_GAP: begin
               if (cnt_q == CW'(BYTE_GAP - 1)) begin
                  cnt_q   <= '0;
                  start_q <= 1'b1;
                  state_q <= ST_SHIFT;
               end else begin
                  cnt_q <= cnt_q + CW'(1);
               end
            end
            ST_DONE: begin
               ss_n_q  <= 1'b1;
               data_q  <= frame_q;
               valid_q <= 1'b1;
               state_q <= ST_IDLE;
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign ss_n  = ss_n_q;
   assign data  = data_q;
   assign valid = valid_q;

endmodule

// File: doc/jstk_spi_master.md
JSTK_SPI_MASTER -- requirements
Module: jstk_spi_master

Interface
REQ-001 Parameter HALF_PERIOD, default 50: clk cycles per SCLK half-period (100 MHz clk gives 1 MHz SCLK).
REQ-002 Parameter SS_SETUP, default 1500: clk cycles from ss_n falling to the first SCLK rising edge (15 us).
REQ-003 Parameter BYTE_GAP, default 1000: clk cycles of SCLK-low idle between bytes (10 us).
REQ-004 Parameter POLL_PERIOD, default 1000000: clk cycles between successive transaction starts (10 ms).
REQ-005 clk  input  1  system clock; all logic SHALL be on its rising edge.
REQ-006 rst  input  1  synchronous, active-high reset.
REQ-007 en  input  1  1 permits polling.
REQ-008 leds  input  2  LED bits sent in command byte.
REQ-009 miso  input  1  serial data from PmodJSTK.
REQ-010 ss_n  output  1  slave select, active low.
REQ-011 sclk  output  1  SPI clock, mode 0, idle low.
REQ-012 mosi  output  1  serial data to PmodJSTK.
REQ-013 data  output  40  last received frame; byte0 at [39:32], byte4 at [7:0].
REQ-014 valid  output  1  one-cycle pulse marking new data.

Function
REQ-015 FSM states SHALL be IDLE, SETUP, SHIFT, GAP, DONE.
REQ-016 IDLE->SETUP when en=1 and poll timer=0; same cycle: ss_n<=0, leds captured, poll timer loaded with POLL_PERIOD-1.
REQ-017 Poll timer SHALL decrement every cycle down to 0 and saturate there; it is never reloaded outside the IDLE->SETUP transition.
REQ-018 SETUP SHALL hold sclk=0 for SS_SETUP cycles, then go to SHIFT.
REQ-019 SHIFT SHALL exchange 8 bits MSB-first: sclk low HALF_PERIOD cycles, high HALF_PERIOD cycles, per bit.
REQ-020 mosi SHALL change only while sclk is low and be stable for at least HALF_PERIOD cycles before each rising edge.
REQ-021 miso SHALL be sampled on the clk cycle sclk goes 0->1.
REQ-022 Transmitted bytes: byte0 = 8'h80 | {6'b0, captured leds}; bytes 1-4 = 8'h00.
REQ-023 After bytes 0-3, SHIFT->GAP (sclk=0, BYTE_GAP cycles)->SHIFT; after byte4, SHIFT->DONE.
REQ-024 DONE, one cycle: ss_n<=1, data<=assembled 40-bit frame, valid<=1; next state IDLE.
REQ-025 valid SHALL be 1 for exactly one cycle per frame; data SHALL change only in that cycle.
REQ-026 en dropping mid-transaction SHALL not abort; the frame completes and no new frame starts while en=0.
REQ-027 If the poll timer is already 0 on return to IDLE, the next frame SHALL start on the following cycle.
REQ-028 Exactly 40 SCLK rising edges SHALL occur per frame, all with ss_n=0.

Reset
REQ-029 rst=1 SHALL set on the next edge: ss_n=1, sclk=0, mosi=0, valid=0, data=0, state IDLE, poll timer=0, bit/byte counters=0.
REQ-030 rst mid-frame SHALL abandon the frame: no valid pulse, data unchanged from its reset value, no further SCLK edges.

Structure
REQ-031 Shared package jstk_pkg SHALL hold the state encoding, CMD_LED = 8'h80, FRAME_BYTES = 5 and FRAME_BITS = 40.
REQ-032 One sub-module spi_byte_shifter (8-bit mode-0 exchange, start/done handshake, HALF_PERIOD parameter) SHALL do SHIFT timing; jstk_spi_master owns the FSM, gaps, poll timer and frame assembly.

Verification (HALF_PERIOD=2, SS_SETUP=4, BYTE_GAP=3, POLL_PERIOD=200)
REQ-033 rst held 3 cycles with en=1 -> ss_n=1, sclk=0, mosi=0, valid=0, data=0 throughout; first ss_n fall on the cycle after rst release.
REQ-034 MISO model returns 8'h00, 8'h02, 8'hFF, 8'h01, 8'h02 -> data=40'h0002FF0102, single valid pulse coincident with ss_n rise, 40 sclk rising edges in 5 groups of 8.
REQ-035 leds=2'b11 -> mosi captured at rising edges = 8'h83, then four 8'h00; leds changed mid-frame -> byte0 unaffected.
REQ-036 Timing checks: ss_n fall to first sclk rise >= 4 cycles; inter-byte sclk-low gap >= 3 + 2 cycles; successive ss_n falls exactly 200 cycles apart.
REQ-037 en cleared during byte 2 -> frame completes with one valid pulse, then ss_n stays 1 for 500 cycles.
REQ-038 rst pulsed during byte 3 -> ss_n=1 and sclk=0 the next cycle, no valid, data=0; next frame starts cleanly after release.
